// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: I2S serializer for the chorus filter output.
// Takes one 16-bit mono sample per enable strobe, holds it in a single-entry
// register, and sends it on both the left and right slots of each I2S frame.
// BCLK, LRCLK and SDATA are all generated from clk. Serial state changes only
// on BCLK falling edges, so the DAC can sample on BCLK rising edges.
module i2s_audio_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] dataIn,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        overrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic [15:0]      hold_q, hold_d;
    logic             pending_q, pending_d;
    logic [31:0]      shift_q, shift_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    logic             div_tc;
    logic             fall_tick;
    logic             fetch;
    logic [15:0]      sample;

    // Next-state logic: divider, bit counter, holding register and shifter.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        shift_d    = shift_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;

        div_tc    = (div_cnt_q == DIV_LAST);
        fall_tick = div_tc && bclk_q;
        // A fetch is the fall tick that moves bit_cnt from 0 to 1.
        fetch     = fall_tick && (bit_cnt_q == 5'd0);
        // A strobe in the fetch cycle bypasses the holding register.
        sample    = enable ? dataIn : hold_q;

        if (div_tc) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (fall_tick) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            lrclk_d   = bit_cnt_d[4];
        end

        if (fetch) begin
            // Same mono sample in both slots; with no fresh sample the last
            // held value repeats and the frame is flagged as starved.
            shift_d    = {sample, sample};
            hold_d     = sample;
            pending_d  = 1'b0;
            underrun_d = !enable && !pending_q;
        end else begin
            if (fall_tick) begin
                shift_d = {shift_q[30:0], 1'b0};
            end
            if (enable) begin
                // Newer sample wins; losing an unsent one is reported.
                hold_d    = dataIn;
                pending_d = 1'b1;
                overrun_d = pending_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            lrclk_q    <= 1'b0;
            hold_q     <= 16'd0;
            pending_q  <= 1'b0;
            shift_q    <= 32'd0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    // The shifter MSB is the registered serial data bit.
    assign sdata    = shift_q[31];
    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule
